regbank_arbiter: RTL and testbench

- Arbiter and sequencer that shares one 4-entry x 32-bit register bank between two requesters, A and B.
- Each granted access is either a write or a read.
- A write stores the incoming data after a selectable scaling: pass, divide-by-2, shift-right-by-2, or clear.
- The block sits between two producer/consumer engines and the shared storage, and serialises all access to that storage.

---
 rtl/regbank_arbiter.sv | 142 ++++++++++++++
 tb/tb_regbank_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter/sequencer giving requesters A and B serialised write/read
// access to a shared 2**ADDR_W x DATA_W register bank; every access is IDLE -> EXEC -> RESP.
module regbank_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [1:0]        a_mode,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_done,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [1:0]        b_mode,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_done,
   output logic [DATA_W-1:0] b_rdata,
   output logic              busy,
   output logic              last_grant
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_mode;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_winner;
   logic                r_last_grant;
   logic                r_a_done;
   logic                r_b_done;
   logic [DATA_W-1:0]   r_a_rdata;
   logic [DATA_W-1:0]   r_b_rdata;
   logic [DATA_W-1:0]   r_bank [DEPTH];

   logic                w_grant_a;
   logic                w_grant_b;
   logic [DATA_W-1:0]   w_scaled;
   logic [DATA_W-1:0]   w_result;

   // On contention the requester that was not served last wins.
   always_comb begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
      if (a_req && b_req) begin
         w_grant_a = r_last_grant;
         w_grant_b = ~r_last_grant;
      end else begin
         w_grant_a = a_req;
         w_grant_b = b_req;
      end
   end

   always_comb begin
      w_scaled = '0;
      case (r_mode)
         2'b00:   w_scaled = r_wdata;
         2'b01:   w_scaled = r_wdata >> 1;
         2'b10:   w_scaled = r_wdata >> 2;
         default: w_scaled = '0;
      endcase
   end

   assign w_result = r_we ? w_scaled : r_bank[r_addr];

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (a_req || b_req) w_next_state = EXEC;
         EXEC:    w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_mode       <= '0;
         r_wdata      <= '0;
         r_winner     <= 1'b0;
         r_last_grant <= 1'b1;
         r_a_done     <= 1'b0;
         r_b_done     <= 1'b0;
         r_a_rdata    <= '0;
         r_b_rdata    <= '0;
         // NOTE: the bank sits inside the reset branch on purpose: reset must clear every entry, so it is built from flops, not a RAM macro.
         for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
      end else begin
         r_a_done <= 1'b0;
         r_b_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_a || w_grant_b) begin
                  r_winner     <= w_grant_b;
                  r_last_grant <= w_grant_b;
                  r_we         <= w_grant_b ? b_we    : a_we;
                  r_addr       <= w_grant_b ? b_addr  : a_addr;
                  r_mode       <= w_grant_b ? b_mode  : a_mode;
                  r_wdata      <= w_grant_b ? b_wdata : a_wdata;
               end
            end
            EXEC: begin
               if (r_we) r_bank[r_addr] <= w_scaled;
               if (r_winner) r_b_rdata <= w_result;
               else          r_a_rdata <= w_result;
               r_a_done <= ~r_winner;
               r_b_done <= r_winner;
            end
            default: ;
         endcase
      end
   end

   assign a_done     = r_a_done;
   assign b_done     = r_b_done;
   assign a_rdata    = r_a_rdata;
   assign b_rdata    = r_b_rdata;
   assign busy       = (r_state != IDLE);
   assign last_grant = r_last_grant;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level bank/arbitration model.
module tb_regbank_arbiter;

   localparam int N_RAND = 1500;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we;
   logic [1:0]  a_addr, a_mode, b_addr, b_mode;
   logic [31:0] a_wdata, b_wdata;
   logic        a_done, b_done, busy, last_grant;
   logic [31:0] a_rdata, b_rdata;

   int checks = 0;
   int failures = 0;
   int a_done_cnt = 0;
   int b_done_cnt = 0;

   regbank_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_mode(a_mode), .a_wdata(a_wdata),
      .a_done(a_done), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_mode(b_mode), .b_wdata(b_wdata),
      .b_done(b_done), .b_rdata(b_rdata),
      .busy(busy), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (a_done === 1'b1) a_done_cnt++;
      if (b_done === 1'b1) b_done_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   function automatic logic [31:0] scale(input logic [31:0] d, input logic [1:0] m);
      case (m)
         2'd0:    return d;
         2'd1:    return d / 2;
         2'd2:    return d / 4;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic done_of(input bit who);
      return who ? b_done : a_done;
   endfunction

   function automatic logic [31:0] rdata_of(input bit who);
      return who ? b_rdata : a_rdata;
   endfunction

   task automatic drive(input bit who, input bit req, input bit we, input logic [1:0] addr,
                        input logic [1:0] mode, input logic [31:0] wdata);
      if (!who) begin
         a_req = req; a_we = we; a_addr = addr; a_mode = mode; a_wdata = wdata;
      end else begin
         b_req = req; b_we = we; b_addr = addr; b_mode = mode; b_wdata = wdata;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Single access; lat counts negedges from raising req to seeing done (-1 on timeout).
   task automatic access(input bit who, input bit we, input logic [1:0] addr, input logic [1:0] mode,
                         input logic [31:0] wdata, output logic [31:0] rd, output int lat);
      rd  = 'x;
      lat = -1;
      drive(who, 1, we, addr, mode, wdata);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (done_of(who) === 1'b1) begin
            lat = i;
            rd  = rdata_of(who);
            break;
         end
      end
      drive(who, 0, 0, 0, 0, 0);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_a_done got=%b exp=0", a_done); end
      checks++; if (b_done !== 1'b0) begin failures++; $display("FAIL reset_b_done got=%b exp=0", b_done); end
      checks++; if (a_rdata !== 32'd0) begin failures++; $display("FAIL reset_a_rdata got=%h exp=0", a_rdata); end
      checks++; if (b_rdata !== 32'd0) begin failures++; $display("FAIL reset_b_rdata got=%h exp=0", b_rdata); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (last_grant !== 1'b1) begin failures++; $display("FAIL reset_last_grant got=%b exp=1", last_grant); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_write_read_div();
      logic [31:0] rd;
      int lat;
      int b_cnt0;
      b_cnt0 = b_done_cnt;
      access(0, 1, 2'd1, 2'b01, 32'h0000_0100, rd, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL div_wr_latency got=%0d exp=2", lat); end
      checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL div_wr_rdata got=%h exp=00000080", rd); end
      access(0, 0, 2'd1, 2'b11, 32'hFFFF_0000, rd, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL div_rd_latency got=%0d exp=2", lat); end
      checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL div_rd_rdata got=%h exp=00000080", rd); end
      #1;
      checks++; if (b_done_cnt !== b_cnt0) begin failures++; $display("FAIL div_b_quiet got=%0d exp=%0d", b_done_cnt, b_cnt0); end
   endtask

   task automatic test_shift_clear();
      logic [31:0] rd;
      int lat;
      access(1, 1, 2'd2, 2'b10, 32'hFFFF_FFFF, rd, lat);
      checks++; if (rd !== 32'h3FFF_FFFF) begin failures++; $display("FAIL shr2_wr got=%h exp=3fffffff", rd); end
      access(1, 0, 2'd2, 2'b00, 32'h0, rd, lat);
      checks++; if (rd !== 32'h3FFF_FFFF) begin failures++; $display("FAIL shr2_rd got=%h exp=3fffffff", rd); end
      access(1, 1, 2'd2, 2'b11, 32'hCAFE_F00D, rd, lat);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL clear_wr got=%h exp=0", rd); end
      access(1, 0, 2'd2, 2'b00, 32'h0, rd, lat);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL clear_rd got=%h exp=0", rd); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL clear_rd_latency got=%0d exp=2", lat); end
   endtask

   task automatic test_contention();
      int a_c, b_c;
      logic [31:0] b_rd;
      a_c = -1; b_c = -1; b_rd = 'x;
      do_reset();
      drive(0, 1, 1, 2'd1, 2'b00, 32'h0000_00A5);
      drive(1, 1, 0, 2'd1, 2'b00, 32'h0);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (a_done === 1'b1) begin
            a_c = c;
            checks++; if (last_grant !== 1'b0) begin failures++; $display("FAIL cont_lg_after_a got=%b exp=0", last_grant); end
            drive(0, 0, 0, 0, 0, 0);
         end
         if (b_done === 1'b1) begin
            b_c = c;
            b_rd = b_rdata;
            checks++; if (last_grant !== 1'b1) begin failures++; $display("FAIL cont_lg_after_b got=%b exp=1", last_grant); end
            drive(1, 0, 0, 0, 0, 0);
         end
         if (a_c >= 0 && b_c >= 0) break;
      end
      checks++; if (a_c !== 2) begin failures++; $display("FAIL cont_a_cycle got=%0d exp=2", a_c); end
      checks++; if (b_c !== 5) begin failures++; $display("FAIL cont_b_cycle got=%0d exp=5", b_c); end
      checks++; if (b_rd !== 32'h0000_00A5) begin failures++; $display("FAIL cont_b_rdata got=%h exp=000000a5", b_rd); end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
   endtask

   // B was served last in the previous scenario, so A opens the alternation.
   task automatic test_held_contention();
      bit is_done, win;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_start_busy got=%b exp=0", busy); end
      drive(0, 1, 0, 2'd0, 2'b00, 32'h0);
      drive(1, 1, 0, 2'd0, 2'b00, 32'h0);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         is_done = (c % 3 == 2);
         win = bit'(((c - 2) / 3) % 2);
         checks++; if (a_done !== (is_done && !win)) begin failures++; $display("FAIL held_a_done c=%0d got=%b exp=%b", c, a_done, is_done && !win); end
         checks++; if (b_done !== (is_done && win)) begin failures++; $display("FAIL held_b_done c=%0d got=%b exp=%b", c, b_done, is_done && win); end
         checks++; if (busy !== (c % 3 != 0)) begin failures++; $display("FAIL held_busy c=%0d got=%b exp=%b", c, busy, c % 3 != 0); end
         if (is_done) begin
            checks++; if (rdata_of(win) !== 32'd0) begin failures++; $display("FAIL held_rdata c=%0d got=%h exp=0", c, rdata_of(win)); end
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
   endtask

   task automatic test_cross_order();
      int a_c, b_c;
      logic [31:0] b_rd;
      a_c = -1; b_c = -1; b_rd = 'x;
      drive(0, 1, 1, 2'd3, 2'b00, 32'h1234_5678);
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (a_done === 1'b1) begin a_c = c; drive(0, 0, 0, 0, 0, 0); end
         if (b_done === 1'b1) begin b_c = c; b_rd = b_rdata; drive(1, 0, 0, 0, 0, 0); end
         if (c == 1) drive(1, 1, 0, 2'd3, 2'b01, 32'hFFFF_FFFF);
         if (a_c >= 0 && b_c >= 0) break;
      end
      checks++; if (a_c !== 2) begin failures++; $display("FAIL cross_a_cycle got=%0d exp=2", a_c); end
      checks++; if (b_c !== 5) begin failures++; $display("FAIL cross_b_cycle got=%0d exp=5", b_c); end
      checks++; if (b_rd !== 32'h1234_5678) begin failures++; $display("FAIL cross_b_rdata got=%h exp=12345678", b_rd); end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
   endtask

   task automatic test_random();
      bit          pend [2];
      bit          t_we [2];
      logic [1:0]  t_addr [2];
      logic [1:0]  t_mode [2];
      logic [31:0] t_wdata [2];
      int          raise_c [2];
      logic [31:0] held [2];
      bit          hist_a [N_RAND];
      bit          hist_b [N_RAND];
      logic [31:0] mbank [4];
      bit          prev_win;
      bit          got [2];
      logic [31:0] v;
      do_reset();
      for (int i = 0; i < 4; i++) mbank[i] = 32'd0;
      for (int w = 0; w < 2; w++) begin pend[w] = 0; held[w] = 32'd0; raise_c[w] = 0; end
      prev_win = 1'b1;
      for (int c = 0; c < N_RAND; c++) begin
         if (c > 0) @(negedge clk);
         checks++; if (a_done === 1'b1 && b_done === 1'b1) begin failures++; $display("FAIL rnd_both_done c=%0d got=11 exp=one", c); end
         for (int w = 0; w < 2; w++) begin
            got[w] = (done_of(bit'(w)) === 1'b1);
            if (got[w]) begin
               checks++;
               if (!pend[w]) begin
                  failures++; $display("FAIL rnd_spurious_done who=%0d c=%0d got=1 exp=0", w, c);
               end else begin
                  if (t_we[w]) begin
                     v = scale(t_wdata[w], t_mode[w]);
                     mbank[t_addr[w]] = v;
                  end else begin
                     v = mbank[t_addr[w]];
                  end
                  if (rdata_of(bit'(w)) !== v) begin failures++; $display("FAIL rnd_rdata who=%0d c=%0d got=%h exp=%h", w, c, rdata_of(bit'(w)), v); end
                  checks++; if (last_grant !== bit'(w)) begin failures++; $display("FAIL rnd_last_grant c=%0d got=%b exp=%0d", c, last_grant, w); end
                  if (c >= 2 && hist_a[c-2] && hist_b[c-2]) begin
                     checks++; if (bit'(w) === prev_win) begin failures++; $display("FAIL rnd_round_robin c=%0d got=%0d exp=%0d", c, w, !prev_win); end
                  end
                  prev_win = bit'(w);
                  held[w] = v;
               end
            end else begin
               checks++; if (rdata_of(bit'(w)) !== held[w]) begin failures++; $display("FAIL rnd_rdata_hold who=%0d c=%0d got=%h exp=%h", w, c, rdata_of(bit'(w)), held[w]); end
               if (pend[w] && (c - raise_c[w]) > 8) begin
                  checks++; failures++;
                  $display("FAIL rnd_starve who=%0d c=%0d waited=%0d exp<=8", w, c, c - raise_c[w]);
                  raise_c[w] = c;
               end
            end
         end
         for (int w = 0; w < 2; w++) begin
            if (got[w] || !pend[w]) begin
               pend[w] = got[w] ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
               if (pend[w]) raise_c[w] = c;
               t_we[w]    = bit'($urandom_range(0, 1));
               t_addr[w]  = 2'($urandom_range(0, 3));
               t_mode[w]  = 2'($urandom_range(0, 3));
               t_wdata[w] = $urandom();
            end
            drive(bit'(w), pend[w], t_we[w], t_addr[w], t_mode[w], t_wdata[w]);
         end
         hist_a[c] = pend[0];
         hist_b[c] = pend[1];
      end
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int lat;
      int a_cnt0;
      access(1, 1, 2'd0, 2'b00, 32'h0000_0055, rd, lat);
      checks++; if (rd !== 32'h0000_0055) begin failures++; $display("FAIL mid_pre_wr got=%h exp=00000055", rd); end
      drive(0, 1, 1, 2'd0, 2'b00, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_in_exec got=%b exp=1", busy); end
      a_cnt0 = a_done_cnt;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL mid_a_done got=%b exp=0", a_done); end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (a_done_cnt !== a_cnt0) begin failures++; $display("FAIL mid_no_done got=%0d exp=%0d", a_done_cnt, a_cnt0); end
      checks++; if (last_grant !== 1'b1) begin failures++; $display("FAIL mid_last_grant got=%b exp=1", last_grant); end
      @(negedge clk);
      access(0, 0, 2'd0, 2'b00, 32'h0, rd, lat);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mid_rd_addr0 got=%h exp=0", rd); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL mid_rd_latency got=%0d exp=2", lat); end
   endtask

   initial begin
      test_reset();
      test_write_read_div();
      test_shift_clear();
      test_contention();
      test_held_contention();
      test_cross_order();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
